// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit common-anode 7-seg scan driver with per-frame input snapshot.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   bcd[11:0]    - packed BCD weight {hundreds, tens, units}
//   ovf          - weight out of displayable range
//   an[3:0]      - digit anodes, active-low, bit 0 = rightmost digit
//   seg[6:0]     - segments {g,f,e,d,c,b,a}, active-low
//   dp           - decimal point, active-low
//   frame        - one-cycle pulse after the snapshot registers load
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int DP_DIGIT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd,
  input  logic        ovf,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(REFRESH_DIV - 1);
  localparam bit DP_EN = (DP_DIGIT >= 0) && (DP_DIGIT < 4);
  localparam logic [1:0] DP_IDX = 2'(DP_DIGIT % 4);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [11:0]   snap_bcd;
  logic          snap_ovf;

  logic          tc;
  logic          last;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg_d;
  logic          dp_on;

  assign tc    = (cnt == CMAX);
  assign last  = tc && (idx == 2'd3);
  assign dp_on = DP_EN && (idx == DP_IDX);

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

`ifdef SEG7_LZ_BLANK_EN
  // Digits at or right of the decimal point always show their value.
  localparam bit KEEP1 = DP_EN && (DP_DIGIT >= 1);
  localparam bit KEEP2 = DP_EN && (DP_DIGIT >= 2);
`endif

  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    unique case (idx)
      2'd0: nib = snap_bcd[3:0];
      2'd1: nib = snap_bcd[7:4];
      2'd2: nib = snap_bcd[11:8];
      default: blank = 1'b1;
    endcase
`ifdef SEG7_LZ_BLANK_EN
    if (idx == 2'd2 && snap_bcd[11:8] == 4'h0 && !KEEP2)
      blank = 1'b1;
    if (idx == 2'd1 && snap_bcd[11:4] == 8'h00 && !KEEP1)
      blank = 1'b1;
`endif
    // Overflow wins over any blanking.
    if (snap_ovf)
      seg_d = (idx == 2'd3) ? 7'h06 : 7'h3F;
    else if (blank)
      seg_d = 7'h7F;
    else
      seg_d = font(nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= 2'd0;
      snap_bcd <= 12'h000;
      snap_ovf <= 1'b0;
      frame    <= 1'b0;
      an       <= 4'hF;
      seg      <= 7'h7F;
      dp       <= 1'b1;
    end else begin
      cnt   <= tc ? '0 : cnt + CW'(1);
      frame <= last;
      if (tc)
        idx <= idx + 2'd1;
      // Snapshot and idx wrap land on the same edge, so digit 0
      // of a new frame already shows the new value.
      if (last) begin
        snap_bcd <= bcd;
        snap_ovf <= ovf;
      end
      an  <= ~(4'b0001 << idx);
      seg <= seg_d;
      dp  <= ~dp_on;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: vector table, directed sequences and random
// stimulus against a frame-level reference model of seg7_scan_driver.
module tb_seg7_scan_driver;

  localparam int RD = 4;
  localparam int FP = 4 * RD;

`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bcd = 12'h000;
  logic        ovf = 1'b0;

  logic [3:0]  a_an, b_an;
  logic [6:0]  a_seg, b_seg;
  logic        a_dp, b_dp, a_fr, b_fr;

  int asserts = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(RD), .DP_DIGIT(4)) u_a (
    .clk(clk), .rst(rst), .bcd(bcd), .ovf(ovf),
    .an(a_an), .seg(a_seg), .dp(a_dp), .frame(a_fr)
  );

  seg7_scan_driver #(.REFRESH_DIV(RD), .DP_DIGIT(1)) u_b (
    .clk(clk), .rst(rst), .bcd(bcd), .ovf(ovf),
    .an(b_an), .seg(b_seg), .dp(b_dp), .frame(b_fr)
  );

  // Reference model: counts edges since reset release; digit shown and
  // frame boundaries follow directly from that count.
  function automatic logic [6:0] mseg(input int k, input logic [11:0] s,
                                      input logic o, input int dpd);
    logic [3:0] n2, n1, nk;
    bit keep, bl;
    n2 = s[11:8];
    n1 = s[7:4];
    nk = (k == 0) ? s[3:0] : (k == 1) ? n1 : n2;
    if (o) return (k == 3) ? 7'h06 : 7'h3F;
    if (k == 3) return 7'h7F;
    keep = (dpd < 4) && (k <= dpd);
    bl = LZ && !keep &&
         ((k == 2 && n2 == 0) || (k == 1 && n2 == 0 && n1 == 0));
    return bl ? 7'h7F : FONT[nk];
  endfunction

  int          n;
  logic [11:0] mbcd;
  logic        movf;
  logic [3:0]  e_an;
  logic [6:0]  e_sa, e_sb;
  logic        e_dpa, e_dpb, e_fr;
  bit          mvalid = 0;

  always @(posedge clk) begin
    mvalid <= 1;
    if (rst) begin
      n <= 0; mbcd <= 12'h0; movf <= 1'b0;
      e_an <= 4'hF; e_sa <= 7'h7F; e_sb <= 7'h7F;
      e_dpa <= 1'b1; e_dpb <= 1'b1; e_fr <= 1'b0;
    end else begin
      e_an  <= ~(4'b0001 << ((n / RD) % 4));
      e_sa  <= mseg((n / RD) % 4, mbcd, movf, 4);
      e_sb  <= mseg((n / RD) % 4, mbcd, movf, 1);
      e_dpa <= 1'b1;
      e_dpb <= !(((n / RD) % 4) == 1);
      e_fr  <= ((n + 1) % FP) == 0;
      if (((n + 1) % FP) == 0) begin
        mbcd <= bcd;
        movf <= ovf;
      end
      n <= n + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mvalid) begin
      chk("model an_a",  a_an,  e_an);
      chk("model an_b",  b_an,  e_an);
      chk("model seg_a", a_seg, e_sa);
      chk("model seg_b", b_seg, e_sb);
      chk("model dp_a",  a_dp,  e_dpa);
      chk("model dp_b",  b_dp,  e_dpb);
      chk("model fr_a",  a_fr,  e_fr);
      chk("model fr_b",  b_fr,  e_fr);
    end
  endtask

  task automatic wait_frame();
    bit got = 0;
    for (int i = 0; i < 3 * FP && !got; i++) begin
      tick();
      got = a_fr;
    end
    asserts++;
    if (!got) begin
      fails++;
      $display("FAIL frame timeout: got 0 expected 1");
    end
  endtask

  typedef struct {
    logic [11:0]     bcd;
    logic            ovf;
    logic [3:0][6:0] sa;
    logic [3:0][6:0] sb;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{12'h305, 1'b0, {7'h7F, 7'h30, 7'h40, 7'h12},
                             {7'h7F, 7'h30, 7'h40, 7'h12}};
    vt[1] = '{12'h007, 1'b0, {7'h7F, 7'h40, 7'h40, 7'h78},
                             {7'h7F, 7'h40, 7'h40, 7'h78}};
    vt[2] = '{12'hA0F, 1'b0, {7'h7F, 7'h3F, 7'h40, 7'h3F},
                             {7'h7F, 7'h3F, 7'h40, 7'h3F}};
    vt[3] = '{12'h000, 1'b1, {7'h06, 7'h3F, 7'h3F, 7'h3F},
                             {7'h06, 7'h3F, 7'h3F, 7'h3F}};
    vt[4] = '{12'h080, 1'b0, {7'h7F, 7'h40, 7'h00, 7'h40},
                             {7'h7F, 7'h40, 7'h00, 7'h40}};
    vt[5] = '{12'h999, 1'b0, {7'h7F, 7'h10, 7'h10, 7'h10},
                             {7'h7F, 7'h10, 7'h10, 7'h10}};
    vt[6] = '{12'h000, 1'b0, {7'h7F, 7'h40, 7'h40, 7'h40},
                             {7'h7F, 7'h40, 7'h40, 7'h40}};
`ifdef SEG7_LZ_BLANK_EN
    vt[1].sa = {7'h7F, 7'h7F, 7'h7F, 7'h78};
    vt[1].sb = {7'h7F, 7'h7F, 7'h40, 7'h78};
    vt[4].sa = {7'h7F, 7'h7F, 7'h00, 7'h40};
    vt[4].sb = {7'h7F, 7'h7F, 7'h00, 7'h40};
    vt[6].sa = {7'h7F, 7'h7F, 7'h7F, 7'h40};
    vt[6].sb = {7'h7F, 7'h7F, 7'h40, 7'h40};
`endif

    // Reset held three cycles.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst an",    a_an,  4'hF);
      chk("rst seg",   a_seg, 7'h7F);
      chk("rst dp",    a_dp,  1'b1);
      chk("rst frame", a_fr,  1'b0);
    end
    rst = 1'b0;

    // Anode scan order and frame spacing.
    for (int j = 1; j <= 2 * FP + 4; j++) begin
      tick();
      chk($sformatf("scan an %0d", j), a_an,
          4'(~(4'b0001 << (((j - 1) / RD) % 4))));
      chk($sformatf("scan frame %0d", j), a_fr, (j % FP) == 0);
    end

    // Vector table: one frame per record.
    foreach (vt[v]) begin
      bcd = vt[v].bcd;
      ovf = vt[v].ovf;
      wait_frame();
      tick();
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("vec%0d an d%0d", v, k), a_an, 4'(~(4'b0001 << k)));
        chk($sformatf("vec%0d seg_a d%0d", v, k), a_seg, vt[v].sa[k]);
        chk($sformatf("vec%0d seg_b d%0d", v, k), b_seg, vt[v].sb[k]);
        chk($sformatf("vec%0d dp_a d%0d", v, k), a_dp, 1'b1);
        chk($sformatf("vec%0d dp_b d%0d", v, k), b_dp, k != 1);
        repeat (RD) tick();
      end
    end

    // Input change mid-frame stays invisible until the next frame.
    bcd = 12'h123;
    wait_frame();
    tick();
    chk("mid d0 old", a_seg, 7'h30);
    repeat (RD) tick();
    bcd = 12'h456;
    chk("mid d1 old", a_seg, 7'h24);
    repeat (RD) tick();
    chk("mid d2 old", a_seg, 7'h79);
    repeat (RD) tick();
    chk("mid d3 old", a_seg, 7'h7F);
    wait_frame();
    tick();
    chk("mid d0 new", a_seg, 7'h02);
    repeat (RD) tick();
    chk("mid d1 new", a_seg, 7'h12);
    repeat (RD) tick();
    chk("mid d2 new", a_seg, 7'h19);

    // Reset pulse in the middle of digit 2; snapshot is cleared.
    bcd = 12'h777;
    wait_frame();
    begin
      bit got = 0;
      for (int i = 0; i < 2 * FP && !got; i++) begin
        tick();
        got = (a_an == 4'hB);
      end
      chk("rst-mid reach d2", got, 1'b1);
    end
    rst = 1'b1;
    tick();
    chk("rst-mid an",    a_an,  4'hF);
    chk("rst-mid seg",   a_seg, 7'h7F);
    chk("rst-mid dp",    a_dp,  1'b1);
    chk("rst-mid frame", a_fr,  1'b0);
    rst = 1'b0;
    tick();
    chk("rst-mid restart an",  a_an,  4'hE);
    chk("rst-mid restart seg", a_seg, 7'h40);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 3) == 0)
          bcd = 12'($urandom);
        else
          bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9))};
        if ($urandom_range(0, 2) == 0)
          bcd[11:8] = 4'h0;
        ovf = ($urandom_range(0, 6) == 0);
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
